mem_sram_ctrl: RTL and testbench
================================

// Module: mem_sram_ctrl
// PURPOSE
//  Memory-stage SRAM controller between the EXE/MEM pipeline register and the MEM/WB register.
//  Turns a 32-bit load/store from the pipeline into two 16-bit half-word accesses on an external SRAM.
//  Each half-word access is timed by a wait-state counter.
//  Drops ready while an access is in flight, which freezes every upstream pipeline register.
// PARAMETERS
//  WAIT_CYCLES  3     cycles each half-word phase is held on the SRAM pins (legal range >=1)
//  ADDR_W       18    SRAM half-word address width
//  BASE_ADDR    1024  byte address that maps to SRAM word 0
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst          in   1       synchronous, active-low reset
//  memReadEn    in   1       load request (held stable while ready=0)
//  memWriteEn   in   1       store request (held stable while ready=0)
//  address      in   32      byte address (ALU result)
//  writeData    in   32      store value
//  ready        out  1       1 = no access pending or access completes this cycle
//  readData     out  32      last completed load word
//  sramAddr     out  ADDR_W  SRAM half-word address
//  sramDqOut    out  16      write data to SRAM
//  sramDqIn     in   16      read data from SRAM
//  sramDqOe     out  1       1 = controller drives the DQ bus
//  sramWeN      out  1       SRAM write enable, active-low
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (rst=0 at edge): state=IDLE, cnt=0, readData=0, captured low half=0.
//   - Reset abandons any access in flight; no partial SRAM write completion is guaranteed.
//   - Outputs follow state (Moore), so after reset: sramAddr=0, sramDqOut=0, sramDqOe=0, sramWeN=1.
//  States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
//  IDLE transitions:
//   - memWriteEn=1 -> WR_LO. memWriteEn has priority when both enables are 1; readData stays unchanged.
//   - else memReadEn=1 -> RD_LO.
//   - else stay in IDLE.
//  Phase timing:
//   - Each LO/HI phase lasts exactly WAIT_CYCLES cycles, timed by cnt counting 0..WAIT_CYCLES-1.
//   - cnt wraps to 0 at every phase change.
//   - LO -> HI, then HI -> DONE, then DONE -> IDLE unconditionally.
//  Address mapping:
//   - off = address - BASE_ADDR (32-bit, modulo 2^32); word = off[ADDR_W:2]. off[1:0] is ignored, no trap.
//   - LO phase: sramAddr = {word[ADDR_W-2:0],1'b0}; HI phase: same with 1'b1. Upper bits beyond the width are dropped.
//  Write phases:
//   - sramDqOe=1, sramWeN=0 for all cycles of the phase.
//   - sramDqOut = writeData[15:0] in LO, writeData[31:16] in HI.
//  Read phases:
//   - sramDqOe=0, sramWeN=1.
//   - sramDqIn is sampled on the last cycle of RD_LO into the low-half register.
//   - On the last cycle of RD_HI, readData <= {sramDqIn, lowHalf}.
//  readData holds its value until the next load completes.
//  ready = (state==DONE) | (state==IDLE & ~memReadEn & ~memWriteEn). It is combinational.
//  Latency: a request first seen in IDLE at cycle 0 gives ready=0 in cycles 0..2*WAIT_CYCLES and ready=1 in cycle 2*WAIT_CYCLES+1 (DONE).
//   - For a load, readData is valid in DONE.
//  Back-to-back requests: the request presented after DONE is seen in IDLE on the next cycle. This gives one IDLE cycle between accesses, with ready=0 in it.
//  Enables dropping mid-access is illegal upstream behaviour; the controller completes the access regardless.
// STRUCTURE
//  Shared package: state enum (6 codes, 3 bits), phase select constants LO=0/HI=1, SRAM data width 16.
//  One sub-module: sram_wait_counter. Inputs clk, rst, clear, max. Outputs cnt and last (cnt==max-1).
//  The controller instantiates it with clear asserted on every state change.
// TESTING (WAIT_CYCLES=3, BASE_ADDR=1024)
//  1 Idle: no enables for 10 cycles -> ready=1 every cycle, sramWeN=1, sramDqOe=0.
//  2 Store: address=1028, writeData=0xDEADBEEF.
//     -> sramAddr=2 with sramDqOut=0xBEEF for cycles 1-3; sramAddr=3 with 0xDEAD for cycles 4-6.
//     -> sramWeN=0 in cycles 1-6; ready=0 in cycles 0-6; ready=1 in cycle 7.
//  3 Load: address=1028 after test 2, SRAM model returns the stored halves -> readData=0xDEADBEEF with ready=1 in cycle 7.
//  4 Both enables at 1: address=1032, writeData=0x12345678 -> write to halves 4/5 only; readData unchanged.
//  5 Reset mid-op: rst=0 in cycle 4 of a store -> next cycle state=IDLE, sramWeN=1, ready=0 while the request is held.
//     -> After rst=1 the access restarts and completes 7 cycles later.
//  6 Back-to-back: store then load to 1036 -> one IDLE gap cycle between the two DONE cycles, and readData = stored value.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_sram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR_LO = 3'd1,
      WR_HI = 3'd2,
      RD_LO = 3'd3,
      RD_HI = 3'd4,
      DONE  = 3'd5
   } state_e;

   localparam logic PH_LO = 1'b0;
   localparam logic PH_HI = 1'b1;
   localparam int SRAM_DW = 16;

   function automatic logic phase_of(state_e s);
      return ((s == WR_HI) || (s == RD_HI)) ? PH_HI : PH_LO;
   endfunction

endpackage

// File: rtl/mem_sram_ctrl_wait_counter.sv
// Wait-state counter: counts 0..max-1 and wraps, flags the final cycle of a phase.
module sram_wait_counter
   import mem_sram_ctrl_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] max,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last = (cnt_q == (max - CNT_W'(1)));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || last) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Splits a 32-bit pipeline load/store into two timed 16-bit SRAM accesses,
// stalling the pipeline via ready while the access is in flight.
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int          WAIT_CYCLES = 3,
   parameter int          ADDR_W      = 18,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               memReadEn,
   input  logic               memWriteEn,
   input  logic [31:0]        address,
   input  logic [31:0]        writeData,
   output logic               ready,
   output logic [31:0]        readData,
   output logic [ADDR_W-1:0]  sramAddr,
   output logic [SRAM_DW-1:0] sramDqOut,
   input  logic [SRAM_DW-1:0] sramDqIn,
   output logic               sramDqOe,
   output logic               sramWeN
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
   logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
   logic [SRAM_DW-1:0] low_q, low_d;
   logic               dq_oe_q, dq_oe_d;
   logic               we_n_q, we_n_d;
   logic [31:0]        read_data_q, read_data_d;
   logic [31:0]        off;
   logic [ADDR_W-2:0]  word;
   logic               last, clear;
   logic [CNT_W-1:0]   cnt_unused;
   logic               unused_off;

   assign off        = address - BASE_ADDR;
   assign word       = off[ADDR_W:2];
   assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};

   // Any state change restarts the phase timer.
   assign clear = (state_d != state_q);

   sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .max   (CNT_W'(WAIT_CYCLES)),
      .cnt   (cnt_unused),
      .last  (last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (memWriteEn) state_d = WR_LO;
                  else if (memReadEn) state_d = RD_LO;
         WR_LO:   if (last) state_d = WR_HI;
         WR_HI:   if (last) state_d = DONE;
         RD_LO:   if (last) state_d = RD_HI;
         RD_HI:   if (last) state_d = DONE;
         default: state_d = IDLE;
      endcase

      // Pin values are registered from the next state so they track state exactly.
      sram_addr_d = '0;
      dq_out_d    = '0;
      dq_oe_d     = 1'b0;
      we_n_d      = 1'b1;
      case (state_d)
         WR_LO, WR_HI: begin
            sram_addr_d = {word, phase_of(state_d)};
            dq_out_d    = (phase_of(state_d) == PH_HI) ? writeData[31:16] : writeData[15:0];
            dq_oe_d     = 1'b1;
            we_n_d      = 1'b0;
         end
         RD_LO, RD_HI: sram_addr_d = {word, phase_of(state_d)};
         default: ;
      endcase

      low_d       = low_q;
      read_data_d = read_data_q;
      if (state_q == RD_LO && last) low_d = sramDqIn;
      if (state_q == RD_HI && last) read_data_d = {sramDqIn, low_q};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         low_q       <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
         low_q       <= low_d;
         read_data_q <= read_data_d;
      end
   end

   assign ready     = (state_q == DONE) || (state_q == IDLE && !memReadEn && !memWriteEn);
   assign readData  = read_data_q;
   assign sramAddr  = sram_addr_q;
   assign sramDqOut = dq_out_q;
   assign sramDqOe  = dq_oe_q;
   assign sramWeN   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a behavioural 16-bit SRAM on the pins.
module tb_mem_sram_ctrl;

   localparam int ADDR_W = 18;

   logic              clk, rst, memReadEn, memWriteEn, ready, sramDqOe, sramWeN;
   logic [31:0]       address, writeData, readData;
   logic [ADDR_W-1:0] sramAddr;
   logic [15:0]       sramDqOut, sramDqIn;
   logic [15:0]       mem [0:(1<<ADDR_W)-1];
   logic [36:0]       act_v;
   int                errors = 0;
   int                checks = 0;

   mem_sram_ctrl #(.WAIT_CYCLES(3), .ADDR_W(ADDR_W), .BASE_ADDR(32'd1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .memReadEn  (memReadEn),
      .memWriteEn (memWriteEn),
      .address    (address),
      .writeData  (writeData),
      .ready      (ready),
      .readData   (readData),
      .sramAddr   (sramAddr),
      .sramDqOut  (sramDqOut),
      .sramDqIn   (sramDqIn),
      .sramDqOe   (sramDqOe),
      .sramWeN    (sramWeN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (!sramWeN) mem[sramAddr] <= sramDqOut;
   assign sramDqIn = mem[sramAddr];
   assign act_v    = {ready, sramWeN, sramDqOe, sramAddr, sramDqOut};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b0; memReadEn = 1'b0; memWriteEn = 1'b0; address = '0; writeData = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (act_v !== {1'b1, 1'b1, 1'b0, 18'd0, 16'd0}) begin
         errors++; $display("FAIL reset_pins: got %h expected %h", act_v, {1'b1, 1'b1, 1'b0, 18'd0, 16'd0});
      end
      checks++;
      if (readData !== 32'd0) begin
         errors++; $display("FAIL reset_readData: got %h expected 0", readData);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_idle();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if ({ready, sramWeN, sramDqOe} !== 3'b110) begin
            errors++; $display("FAIL idle cyc%0d: rdy/weN/oe got %b expected 110", k, {ready, sramWeN, sramDqOe});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store();
      logic [36:0] exp_v;
      logic        we_n;
      memWriteEn = 1'b1; address = 32'd1028; writeData = 32'hDEADBEEF;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         we_n  = !(k >= 1 && k <= 6);
         exp_v = {(k == 7 || k == 8), we_n, ~we_n,
                  (k >= 1 && k <= 3) ? 18'd2 : (k >= 4 && k <= 6) ? 18'd3 : 18'd0,
                  (k >= 1 && k <= 3) ? 16'hBEEF : (k >= 4 && k <= 6) ? 16'hDEAD : 16'h0};
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL store cyc%0d: got %h expected %h", k, act_v, exp_v);
         end
         @(posedge clk); #1;
         if (k == 7) memWriteEn = 1'b0;
      end
   endtask

   task automatic test_load();
      logic [36:0] exp_v;
      memReadEn = 1'b1; address = 32'd1028;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         exp_v = {(k == 7), 1'b1, 1'b0,
                  (k >= 1 && k <= 3) ? 18'd2 : (k >= 4 && k <= 6) ? 18'd3 : 18'd0, 16'h0};
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL load cyc%0d: got %h expected %h", k, act_v, exp_v);
         end
         if (k == 6 || k == 7) begin
            checks++;
            if (readData !== ((k == 7) ? 32'hDEADBEEF : 32'h0)) begin
               errors++; $display("FAIL load_data cyc%0d: got %h expected %h", k, readData,
                                  (k == 7) ? 32'hDEADBEEF : 32'h0);
            end
         end
         @(posedge clk); #1;
      end
      memReadEn = 1'b0;
   endtask

   task automatic test_both_enables();
      logic [36:0] exp_v;
      logic        we_n;
      memWriteEn = 1'b1; memReadEn = 1'b1; address = 32'd1032; writeData = 32'h12345678;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         we_n  = !(k >= 1 && k <= 6);
         exp_v = {(k == 7), we_n, ~we_n,
                  (k >= 1 && k <= 3) ? 18'd4 : (k >= 4 && k <= 6) ? 18'd5 : 18'd0,
                  (k >= 1 && k <= 3) ? 16'h5678 : (k >= 4 && k <= 6) ? 16'h1234 : 16'h0};
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL both cyc%0d: got %h expected %h", k, act_v, exp_v);
         end
         @(posedge clk); #1;
      end
      memWriteEn = 1'b0; memReadEn = 1'b0;
      @(negedge clk);
      checks++;
      if (readData !== 32'hDEADBEEF) begin
         errors++; $display("FAIL both_readData: got %h expected deadbeef", readData);
      end
      checks++;
      if ({mem[4], mem[5], mem[2], mem[3]} !== 64'h5678_1234_BEEF_DEAD) begin
         errors++; $display("FAIL both_sram: got %h expected 56781234beefdead", {mem[4], mem[5], mem[2], mem[3]});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      logic [36:0] exp_v;
      logic        we_n;
      int          j;
      memWriteEn = 1'b1; address = 32'd1040; writeData = 32'hAAAA5555;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         j     = (k >= 5) ? k - 5 : k;
         we_n  = !(j >= 1 && j <= 6);
         exp_v = {(j == 7), we_n, ~we_n,
                  (j >= 1 && j <= 3) ? 18'd8 : (j >= 4 && j <= 6) ? 18'd9 : 18'd0,
                  (j >= 1 && j <= 3) ? 16'h5555 : (j >= 4 && j <= 6) ? 16'hAAAA : 16'h0};
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL rst_mid cyc%0d: got %h expected %h", k, act_v, exp_v);
         end
         @(posedge clk); #1;
         if (k == 3) rst = 1'b0;
         if (k == 4) rst = 1'b1;
      end
      memWriteEn = 1'b0;
      @(negedge clk);
      checks++;
      if ({ready, readData} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL rst_mid_after: rdy/readData got %h expected 100000000", {ready, readData});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [36:0] exp_v;
      logic        we_n;
      int          r;
      memWriteEn = 1'b1; address = 32'd1036; writeData = 32'hCAFEF00D;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         if (k <= 7) begin
            we_n  = !(k >= 1 && k <= 6);
            exp_v = {(k == 7), we_n, ~we_n,
                     (k >= 1 && k <= 3) ? 18'd6 : (k >= 4 && k <= 6) ? 18'd7 : 18'd0,
                     (k >= 1 && k <= 3) ? 16'hF00D : (k >= 4 && k <= 6) ? 16'hCAFE : 16'h0};
         end else begin
            r     = k - 8;
            exp_v = {(r == 7), 1'b1, 1'b0,
                     (r >= 1 && r <= 3) ? 18'd6 : (r >= 4 && r <= 6) ? 18'd7 : 18'd0, 16'h0};
         end
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL b2b cyc%0d: got %h expected %h", k, act_v, exp_v);
         end
         if (k == 14 || k == 15) begin
            checks++;
            if (readData !== ((k == 15) ? 32'hCAFEF00D : 32'h0)) begin
               errors++; $display("FAIL b2b_data cyc%0d: got %h expected %h", k, readData,
                                  (k == 15) ? 32'hCAFEF00D : 32'h0);
            end
         end
         @(posedge clk); #1;
         if (k == 7) begin
            memWriteEn = 1'b0; memReadEn = 1'b1;
         end
      end
      memReadEn = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++; $display("FAIL b2b_idle: ready got %b expected 1", ready);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_store();
      test_load();
      test_both_enables();
      test_reset_mid_op();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
